pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (posedge) and rst.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc_value  in  16  current PC from the PC unit.
- pc_en  out  1  PC unit enable.
- pc_op  out  2  PC operation: NOP=00, INC=01, SET=10, RESET=11.
- pc_target  out  16  PC load value, valid when pc_op=SET.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  16  read address.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  16  read data.
- instr  out  16  fetched opcode word.
- imm  out  16  fetched immediate word; 0 for one-word instructions.
- instr_valid  out  1  instruction offered to execute stage.
- instr_ack  in  1  execute stage accepts instruction.
- branch_taken  in  1  qualifies instr_ack; redirect PC.
- branch_target  in  16  redirect address.

Function
REQ-003 The FSM SHALL have states S_RESET, S_FETCH, S_FETCH_IMM and S_ISSUE, encoded in 2 bits.
REQ-004 pc_en, pc_op, pc_target, mem_req and mem_addr SHALL be combinational from state and inputs; instr, imm and instr_valid SHALL be registered.
REQ-005 Default outputs SHALL be: pc_en=0, pc_op=NOP, pc_target=0, mem_req=0, mem_addr=pc_value.
REQ-006 S_RESET SHALL drive pc_en=1 and pc_op=RESET for exactly one cycle, then go to S_FETCH; mem_ack SHALL be ignored in this state.
REQ-007 S_FETCH SHALL hold mem_req=1 and mem_addr=pc_value until mem_ack.
REQ-008 On mem_ack in S_FETCH, the block SHALL:
- latch instr=mem_rdata and imm=0;
- drive pc_en=1, pc_op=INC;
- go to S_FETCH_IMM if mem_rdata[15]=1, else to S_ISSUE.
REQ-009 S_FETCH_IMM SHALL hold mem_req=1 and mem_addr=pc_value, which is already the incremented PC.
REQ-010 On mem_ack in S_FETCH_IMM, the block SHALL latch imm=mem_rdata, drive pc_en=1 with pc_op=INC, and go to S_ISSUE.
REQ-011 instr_valid SHALL be 1 exactly while in S_ISSUE; instr and imm SHALL be stable in S_ISSUE; mem_req SHALL be 0 in S_ISSUE.
REQ-012 On instr_ack with branch_taken=0 in S_ISSUE, the block SHALL go to S_FETCH with pc_en=0.
REQ-013 On instr_ack with branch_taken=1 in S_ISSUE, the block SHALL drive pc_en=1, pc_op=SET and pc_target=branch_target in that cycle, then go to S_FETCH.
REQ-014 branch_taken without instr_ack, and instr_ack outside S_ISSUE, SHALL be ignored.
REQ-015 mem_ack may arrive in the same cycle mem_req is first asserted, giving a one-cycle fetch; no minimum latency SHALL be required.
REQ-016 The PC SHALL wrap modulo 2^16; the block SHALL do no range checking, so INC from 0xFFFE yields 0x0000.
REQ-017 A fetch SHALL NOT be aborted once started; the only exit from S_FETCH and S_FETCH_IMM SHALL be mem_ack or rst.

Reset
REQ-018 While rst=1 at a clock edge, the next state SHALL be S_RESET and instr=0, imm=0, instr_valid=0.
REQ-019 While rst=1, combinational outputs SHALL be forced to pc_en=0 and mem_req=0.
REQ-020 The first cycle after rst falls SHALL be the single PC RESET cycle of REQ-006.
REQ-021 Reset mid-fetch or mid-issue SHALL discard the pending instruction; a late mem_ack SHALL be ignored.

Verification
REQ-022 Reset then one-word fetch: rst 2 cycles, mem_ack=1 with rdata=0x1234 in the first S_FETCH cycle -> one RESET cycle, mem_addr=0x0000, INC, then instr=0x1234, imm=0, instr_valid=1 next cycle.
REQ-023 Two-word fetch: rdata 0x8001 then 0xBEEF, each with 2 wait cycles -> mem_addr 0x0000 then 0x0002, two INC pulses, instr=0x8001, imm=0xBEEF, PC=0x0004.
REQ-024 Branch: in S_ISSUE assert instr_ack=1, branch_taken=1, branch_target=0x0100 -> one SET cycle with pc_target=0x0100; next mem_addr=0x0100.
REQ-025 Back-pressure: hold instr_ack=0 for 5 cycles -> instr_valid stays 1, instr/imm stable, mem_req=0, pc_en=0.
REQ-026 Reset mid-fetch: rst=1 while in S_FETCH_IMM, then mem_ack after rst falls -> S_RESET, PC=0, instr_valid=0, late ack ignored, fetch restarts at 0x0000.
REQ-027 Wrap: PC=0xFFFE, one-word fetch -> INC makes pc_value=0x0000, next mem_addr=0x0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Purpose: fetch sequencer that drives the PC unit and instruction memory, offering 1- or 2-word instructions.
// Latency: a fetch takes one cycle per word plus memory wait cycles; the instruction is offered the cycle after its last ack.
// Backpressure: holds the instruction in S_ISSUE, with no memory request, until instr_ack; waits on mem_ack indefinitely.
module pc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_value,
    output logic        pc_en,
    output logic [1:0]  pc_op,
    output logic [15:0] pc_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] imm,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch_taken,
    input  logic [15:0] branch_target
);

    typedef enum logic [1:0] {
        S_RESET     = 2'd0,
        S_FETCH     = 2'd1,
        S_FETCH_IMM = 2'd2,
        S_ISSUE     = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    state_t state;
    state_t state_next;

    // Next-state and PC/memory control; rst masks the enables so nothing moves while held in reset.
    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        pc_op      = OP_NOP;
        pc_target  = 16'h0000;
        mem_req    = 1'b0;
        mem_addr   = pc_value;
        case (state)
            S_RESET: begin
                pc_en      = 1'b1;
                pc_op      = OP_RESET;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_en      = 1'b1;
                    pc_op      = OP_INC;
                    // Bit 15 of the opcode word flags a trailing immediate word.
                    state_next = mem_rdata[15] ? S_FETCH_IMM : S_ISSUE;
                end
            end
            S_FETCH_IMM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_en      = 1'b1;
                    pc_op      = OP_INC;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ack) begin
                    state_next = S_FETCH;
                    if (branch_taken) begin
                        pc_en     = 1'b1;
                        pc_op     = OP_SET;
                        pc_target = branch_target;
                    end
                end
            end
            default: state_next = S_RESET;
        endcase
        if (rst) begin
            pc_en   = 1'b0;
            mem_req = 1'b0;
        end
    end

    // State register and instruction latches; reset discards any partly fetched instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            instr       <= 16'h0000;
            imm         <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            instr_valid <= (state_next == S_ISSUE);
            if (state == S_FETCH && mem_ack) begin
                instr <= mem_rdata;
                imm   <= 16'h0000;
            end
            if (state == S_FETCH_IMM && mem_ack) begin
                imm <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: self-checking bench for pc_sequencer with a byte-addressed PC unit (INC adds 2) and a random memory.
// Latency: lockstep stimulus on negedge; combinational outputs sampled 1 time unit after inputs change.
// Backpressure: random memory wait states and random execute-stage stalls.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_value;
    logic        pc_en;
    logic [1:0]  pc_op;
    logic [15:0] pc_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        instr_valid;
    logic        instr_ack;
    logic        branch_taken;
    logic [15:0] branch_target;

    int checks = 0;
    int errors = 0;

    // Reference view of where the PC should be, advanced by instruction-level rules.
    logic [15:0] mpc;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc_value(pc_value), .pc_en(pc_en), .pc_op(pc_op),
        .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr(instr), .imm(imm), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    // PC unit: byte-addressed, so INC steps by one 16-bit word (2 bytes), wrapping at 2^16.
    always @(posedge clk) begin
        if (pc_en) begin
            case (pc_op)
                2'b01:   pc_value <= pc_value + 16'd2;
                2'b10:   pc_value <= pc_target;
                2'b11:   pc_value <= 16'h0000;
                default: pc_value <= pc_value;
            endcase
        end
    end

    task automatic idle_inputs();
        mem_ack = 1'b0; mem_rdata = 16'h0000; instr_ack = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0000;
    endtask

    // Hold reset for n cycles, then release and step through the PC RESET cycle into S_FETCH.
    task automatic do_reset(input int n);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mpc = 16'h0000;
    endtask

    // Fetch one instruction starting in S_FETCH and retire it. Leaves the DUT in S_FETCH.
    task automatic do_instr(input logic [15:0] w0, input logic [15:0] w1, input int wait0,
                            input int wait1, input int stall, input logic br, input logic [15:0] tgt);
        logic [15:0] exp_imm;
        int nwords;
        nwords = w0[15] ? 2 : 1;
        exp_imm = 16'h0000;
        for (int wd = 0; wd < nwords; wd++) begin
            for (int i = 0; i < (wd == 0 ? wait0 : wait1); i++) begin
                mem_ack = 1'b0;
                instr_ack = 1'($urandom_range(0, 1));
                branch_taken = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== mpc || pc_en !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_wait: req=%b addr=%h pc_en=%b, want req=1 addr=%h pc_en=0",
                             mem_req, mem_addr, pc_en, mpc);
                end
                @(negedge clk);
            end
            instr_ack = 1'b0; branch_taken = 1'b0;
            mem_ack = 1'b1;
            mem_rdata = (wd == 0) ? w0 : w1;
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== mpc || pc_en !== 1'b1 || pc_op !== 2'b01) begin
                errors++;
                $display("FAIL fetch_ack: req=%b addr=%h pc_en=%b op=%b, want req=1 addr=%h pc_en=1 op=01",
                         mem_req, mem_addr, pc_en, pc_op, mpc);
            end
            @(negedge clk);
            mpc = mpc + 16'd2;
            if (wd == 1) exp_imm = w1;
            mem_ack = 1'b0; mem_rdata = 16'h0000;
        end
        checks++;
        if (pc_value !== mpc) begin
            errors++;
            $display("FAIL pc_after_fetch: pc=%h want %h", pc_value, mpc);
        end
        for (int i = 0; i <= stall; i++) begin
            branch_target = 16'($urandom);
            if (i == stall) begin
                instr_ack = 1'b1; branch_taken = br; branch_target = tgt;
            end else begin
                instr_ack = 1'b0; branch_taken = 1'($urandom_range(0, 1));
                mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
            end
            #1;
            checks++;
            if (instr_valid !== 1'b1 || instr !== w0 || imm !== exp_imm || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL issue: vld=%b instr=%h imm=%h req=%b, want vld=1 instr=%h imm=%h req=0",
                         instr_valid, instr, imm, mem_req, w0, exp_imm);
            end
            checks++;
            if (i < stall && pc_en !== 1'b0) begin
                errors++;
                $display("FAIL issue_stall_pc: pc_en=%b want 0", pc_en);
            end else if (i == stall && (pc_en !== br || (br && (pc_op !== 2'b10 || pc_target !== tgt)))) begin
                errors++;
                $display("FAIL issue_ack: pc_en=%b op=%b tgt=%h, want pc_en=%b op=10 tgt=%h",
                         pc_en, pc_op, pc_target, br, tgt);
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        idle_inputs();
        if (br) mpc = tgt;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== mpc) begin
            errors++;
            $display("FAIL refetch: vld=%b req=%b addr=%h, want vld=0 req=1 addr=%h",
                     instr_valid, mem_req, mem_addr, mpc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (pc_en !== 1'b0 || mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0 || imm !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold: pc_en=%b req=%b vld=%b instr=%h imm=%h, want all 0",
                         pc_en, mem_req, instr_valid, instr, imm);
            end
        end
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h8000;
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_op !== 2'b11 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle: pc_en=%b op=%b req=%b, want 1 11 0", pc_en, pc_op, mem_req);
        end
        @(negedge clk);
        idle_inputs();
        mpc = 16'h0000;
        #1;
        checks++;
        if (pc_value !== 16'h0000 || mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_fetch: pc=%h req=%b addr=%h vld=%b, want 0000 1 0000 0",
                     pc_value, mem_req, mem_addr, instr_valid);
        end
    endtask

    task automatic test_one_word();
        do_reset(2);
        do_instr(16'h1234, 16'h0000, 0, 0, 0, 1'b0, 16'h0000);
    endtask

    task automatic test_two_word();
        do_reset(2);
        do_instr(16'h8001, 16'hBEEF, 2, 2, 0, 1'b0, 16'h0000);
        checks++;
        if (pc_value !== 16'h0004) begin
            errors++;
            $display("FAIL two_word_pc: pc=%h want 0004", pc_value);
        end
    endtask

    task automatic test_branch();
        do_reset(1);
        do_instr(16'h0042, 16'h0000, 1, 0, 0, 1'b1, 16'h0100);
        do_instr(16'h8A00, 16'h1357, 0, 1, 0, 1'b0, 16'h0000);
        checks++;
        if (pc_value !== 16'h0104) begin
            errors++;
            $display("FAIL branch_pc: pc=%h want 0104", pc_value);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        do_instr(16'h9111, 16'h2222, 1, 0, 5, 1'b0, 16'h0000);
    endtask

    task automatic test_reset_mid_fetch();
        do_reset(1);
        mem_ack = 1'b1; mem_rdata = 16'h8555;
        @(negedge clk);
        mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (pc_en !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_outputs: pc_en=%b req=%b, want 0 0", pc_en, mem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0 || pc_en !== 1'b1 || pc_op !== 2'b11 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_cycle: vld=%b instr=%h pc_en=%b op=%b req=%b, want 0 0000 1 11 0",
                     instr_valid, instr, pc_en, pc_op, mem_req);
        end
        @(negedge clk);
        idle_inputs();
        mpc = 16'h0000;
        do_instr(16'h0777, 16'h0000, 1, 0, 1, 1'b0, 16'h0000);
    endtask

    task automatic test_wrap();
        do_reset(1);
        do_instr(16'h0001, 16'h0000, 0, 0, 0, 1'b1, 16'hFFFE);
        do_instr(16'h0002, 16'h0000, 1, 0, 0, 1'b0, 16'h0000);
        checks++;
        if (pc_value !== 16'h0000 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: pc=%h addr=%h want 0000 0000", pc_value, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w0, w1, tgt;
        logic br;
        do_reset(1);
        for (int n = 0; n < 60; n++) begin
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            br = ($urandom_range(0, 3) == 0);
            tgt = 16'($urandom) & 16'hFFFE;
            do_instr(w0, w1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br, tgt);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_one_word();
        test_two_word();
        test_branch();
        test_backpressure();
        test_reset_mid_fetch();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
